// File: rtl/csa_final_cpa.sv
// Serial carry-propagate stage behind the last CSA row: resolves sum + (carry << 1)
// SLICE bits per cycle and appends the already-resolved low product bits.
module csa_final_cpa #(
    parameter int W     = 8,
    parameter int LO_W  = 8,
    parameter int SLICE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          sum_in,
    input  logic [W-1:0]          carry_in,
    input  logic [LO_W-1:0]       lo_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W+2+LO_W-1:0]   prod_out,
    output logic                  busy
);

    localparam int N  = W + 2;
    localparam int NS = N / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam int BW = $clog2(N);

    generate
        if ((N % SLICE) != 0) begin : g_bad_slice
            $error("csa_final_cpa: (W+2) must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            cy_q, cy_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    res_q, res_d;
    logic [LO_W-1:0] lo_q, lo_d;

    logic [SLICE:0]  slice_sum;
    logic [BW-1:0]   base;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cy_d      = cy_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        lo_d      = lo_q;
        slice_sum = '0;
        base      = BW'(int'(idx_q) * SLICE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Carry vector is stored pre-shifted so both operands share bit weights.
                    a_d     = {2'b00, sum_in};
                    b_d     = {1'b0, carry_in, 1'b0};
                    lo_d    = lo_in;
                    res_d   = '0;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                slice_sum = {1'b0, a_q[base +: SLICE]}
                          + {1'b0, b_q[base +: SLICE]}
                          + (SLICE+1)'(cy_q);
                res_d[base +: SLICE] = slice_sum[SLICE-1:0];
                cy_d  = slice_sum[SLICE];
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(NS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            lo_q    <= lo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign prod_out  = {res_q, lo_q};

endmodule

// File: tb/tb_csa_final_cpa.sv
// Randomized self-checking bench for csa_final_cpa against an arithmetic reference model.
module tb_csa_final_cpa;

    localparam int W     = 8;
    localparam int LO_W  = 8;
    localparam int SLICE = 2;
    localparam int N     = W + 2;
    localparam int PW    = N + LO_W;
    localparam int LAT   = N / SLICE;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    sum_in;
    logic [W-1:0]    carry_in;
    logic [LO_W-1:0] lo_in;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   prod_out;
    logic            busy;

    csa_final_cpa #(.W(W), .LO_W(LO_W), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .lo_in     (lo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_out  (prod_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] s, input logic [W-1:0] c,
                                               input logic [LO_W-1:0] l);
        int unsigned r;
        r = int'(s) + 2 * int'(c);
        return {r[N-1:0], l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sees handshakes half a cycle before the edge that completes them.
    logic [PW-1:0] exp_q[$];
    int            acc_cyc  = 0;
    bit            have_acc = 1'b0;
    bit            wait_ov  = 1'b0;
    int            n_acc    = 0;
    int            n_res    = 0;
    bit            ov_prev  = 1'b0;
    bit            hold_prev = 1'b0;
    bit            rst_prev = 1'b0;
    logic [PW-1:0] prod_prev = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                n_acc   -= exp_q.size();
                exp_q.delete();
                wait_ov  = 1'b0;
                have_acc = 1'b0;
            end else begin
                if (hold_prev && !rst_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_prod", prod_out, prod_prev);
                end
                if (out_valid && !ov_prev && !rst_prev) begin
                    chk("ov_expected", wait_ov, 1);
                    chk("latency", cyc - acc_cyc, LAT + 1);
                    wait_ov = 1'b0;
                end
                if (in_valid && in_ready) begin
                    if (have_acc) chk("issue_gap", (cyc - acc_cyc) >= LAT + 2, 1);
                    exp_q.push_back(ref_prod(sum_in, carry_in, lo_in));
                    acc_cyc  = cyc;
                    have_acc = 1'b1;
                    wait_ov  = 1'b1;
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    chk("res_present", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("prod", prod_out, exp_q.pop_front());
                    n_res++;
                end
            end
            ov_prev   = out_valid;
            hold_prev = out_valid && !out_ready;
            prod_prev = prod_out;
            rst_prev  = rst;
        end
    end

    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] c, input logic [LO_W-1:0] l,
                          input logic [PW-1:0] exp, input string tag);
        int n;
        sum_in = s; carry_in = c; lo_in = l;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        chk({tag, "_acc_wait"}, n < 50, 1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_prod"}, prod_out, exp);
        step();
        chk({tag, "_idle"}, in_ready, 1);
        chk({tag, "_ov_low"}, out_valid, 0);
    endtask

    initial begin
        int n;
        bit hs;
        logic [PW-1:0] exp_a, exp_b;

        // Reset with in_valid held high: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        sum_in = 8'h3C; carry_in = 8'h11; lo_in = 8'h77;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_prod", prod_out, 0);
        rst = 1'b0; in_valid = 1'b0;
        mon_en = 1'b1;
        step();

        run_op(8'h0F, 8'h01, 8'hA5, {10'h011, 8'hA5}, "basic");
        run_op(8'hFF, 8'hFF, 8'h00, {10'h2FD, 8'h00}, "max");
        run_op(8'h00, 8'h00, 8'h00, '0, "zero");

        // Backpressure with a second operand set waiting upstream.
        exp_a = {10'h0C8, 8'h5C};
        exp_b = {10'h101, 8'h12};
        sum_in = 8'h3A; carry_in = 8'h47; lo_in = 8'h5C;
        in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        step();
        sum_in = 8'h81; carry_in = 8'h40; lo_in = 8'h12;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("bp_done_wait", n < 20, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_ov", out_valid, 1);
            chk("bp_prod", prod_out, exp_a);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_not_taken", in_ready, 1);
        chk("bp_ov_low", out_valid, 0);
        chk("bp_prod_kept", prod_out, exp_a);
        step();
        chk("bp_taken", busy, 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("bp_second_prod", prod_out, exp_b);
        step();

        // Reset during the second ADD cycle discards the operation.
        sum_in = 8'h55; carry_in = 8'hAA; lo_in = 8'h3C;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_prod", prod_out, 0);
        chk("mid_rst_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            chk("mid_rst_no_ov", out_valid, 0);
            step();
        end
        run_op(8'h01, 8'h01, 8'h00, {10'h003, 8'h00}, "after_rst");

        // Random traffic with idle gaps and random downstream stalls.
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            sum_in   = W'($urandom);
            carry_in = W'($urandom);
            lo_in    = LO_W'($urandom);
            in_valid = 1'b1;
            n = 0;
            do begin
                out_ready = ($urandom_range(0, 3) != 0);
                hs = in_ready;
                step();
                n++;
            end while (!hs && n < 100);
            chk("rnd_acc_wait", hs, 1);
        end

        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin step(); n++; end
        chk("drain", busy, 0);
        step();
        chk("res_count", n_res, n_acc);
        chk("q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csa_final_cpa.md
Name: csa_final_cpa

Overview:
- Carry-propagate stage placed directly downstream of the last carry-save row of the array multiplier.
- Takes the redundant sum/carry vector pair from that row, plus the low product bits already resolved by earlier rows.
- Resolves the pair into a binary result serially, SLICE bits per clock, behind valid/ready handshakes on both sides.
- Trades latency for a short carry chain per cycle.

Parameters:
- W, 8: width of the sum and carry vectors from the CSA row.
- LO_W, 8: width of the already-resolved low product bits, passed through unchanged.
- SLICE, 2: bits resolved per ADD cycle. (W+2) must be a multiple of SLICE. Elaboration error otherwise.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  block can accept operands.
- sum_in  in  W  sum vector; bit i has weight 2^i.
- carry_in  in  W  carry vector; bit i has weight 2^(i+1).
- lo_in  in  LO_W  resolved low product bits.
- out_valid  out  1  prod_out holds a completed result.
- out_ready  in  1  downstream accepts the result.
- prod_out  out  W+2+LO_W  {sum_in + (carry_in<<1), lo_in}.
- busy  out  1  high in ADD or DONE.

Behaviour:
- Arithmetic: res = zero-extended sum_in + (carry_in<<1), computed on N = W+2 bits. No truncation or overflow is possible, since the maximum is (2^W-1) + (2^(W+1)-2) < 2^(W+2).
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ADD: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (rst=1 at an edge): state=IDLE; slice index=0; carry register=0; result register=0; lo register=0. Outputs next cycle: in_ready=1, out_valid=0, busy=0, prod_out=0. Reset wins over every other event, including mid-ADD and mid-DONE. Any in-flight operation is discarded with no output.
- IDLE -> ADD on an edge with in_valid=1 (in_ready is 1):
  - latch both operands, zero-extended to N bits, and lo_in;
  - clear the result register, slice index and carry register.
- ADD: each cycle resolves bits [idx*SLICE +: SLICE] with the registered carry-in, writes those result bits, updates the carry register and increments idx.
- After slice N/SLICE-1: ADD -> DONE.
- Latency: out_valid rises exactly N/SLICE edges after the accept edge (5 for the defaults).
- The final carry-out is provably 0 and is not exported.
- DONE: prod_out and out_valid are held stable while out_ready=0, for any number of cycles.
  - Edge with out_ready=1: DONE -> IDLE, out_valid=0.
  - prod_out keeps its last value until the next accept.
- No overlap: a new operand is accepted no earlier than the edge after the DONE->IDLE transfer. Minimum issue interval is N/SLICE+2 cycles.
- in_valid while not in IDLE is ignored. Operands must be re-presented by upstream, which holds them until the handshake.
- out_ready while not in DONE has no effect.
- prod_out is registered only. No combinational path from any input to any output except through state.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, prod_out=0; no accept occurs during reset.
- Basic: sum_in=0x0F, carry_in=0x01, lo_in=0xA5, out_ready=1 -> out_valid exactly 5 cycles after accept; prod_out = {10'h011, 8'hA5}; back in IDLE one cycle later.
- Maximum operands: sum_in=0xFF, carry_in=0xFF, lo_in=0x00 -> result 10'h2FD, which exercises carry across every slice boundary; zeros (0,0) -> result 0.
- Backpressure: complete an operation with out_ready=0 for 4 cycles while driving in_valid=1 with different operands -> prod_out and out_valid stable, in_ready=0, second operands not taken until the cycle after out_ready=1.
- Reset mid-operation: rst for one cycle at ADD cycle 2 of sum_in=0x55, carry_in=0xAA -> next cycle IDLE, prod_out=0, out_valid never asserted for that operation; a following op 0x01+0x01 gives result 10'h003.
- Back-to-back plus random: 1000 random sum/carry/lo triples with random in_valid/out_ready gaps -> every prod_out equals the reference sum, no result lost or duplicated, issue interval never below 7 cycles.
